// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a registered one-cycle register-file write on completion.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic            RegWrite
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] mcand;
    logic            res_neg;

    logic            is_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;

    // Operand decode at the accept edge: signedness, magnitudes and special cases
    always_comb begin
        is_div   = funct3[2];
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        if (is_div) begin
            a_neg = ~funct3[0] & op_a[XLEN-1];
            b_neg = ~funct3[0] & op_b[XLEN-1];
        end else begin
            a_neg = (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10) & op_a[XLEN-1];
            b_neg = (funct3[1:0] == 2'b01) & op_b[XLEN-1];
        end
        mag_a    = a_neg ? (XLEN'(0) - op_a) : op_a;
        mag_b    = b_neg ? (XLEN'(0) - op_b) : op_b;
        div_zero = (op_b == '0);
        div_ovf  = ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    // One iteration step; the divide relies on acc_hi staying below the divisor
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   div_fix;
    logic [XLEN-1:0]   result;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = res_neg ? ((2*XLEN)'(0) - prod) : prod;
        div_val  = funct3_q[1] ? acc_hi : acc_lo;
        div_fix  = res_neg ? (XLEN'(0) - div_val) : div_val;
        if (funct3_q[2]) begin
            result = div_fix;
        end else if (funct3_q[1:0] == 2'b00) begin
            result = prod_fix[XLEN-1:0];
        end else begin
            result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath; a new request is refused during the done pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            count      <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            mcand      <= '0;
            res_neg    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            RegWrite   <= 1'b0;
        end else begin
            done       <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            RegWrite   <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        funct3_q <= funct3;
                        rd_q     <= rd;
                        count    <= '0;
                        busy     <= 1'b1;
                        if (is_div && div_zero) begin
                            acc_hi  <= op_a;
                            acc_lo  <= '1;
                            mcand   <= '0;
                            res_neg <= 1'b0;
                            state   <= DONE;
                        end else if (is_div && div_ovf) begin
                            acc_hi  <= '0;
                            acc_lo  <= op_a;
                            mcand   <= op_b;
                            res_neg <= 1'b0;
                            state   <= DONE;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= is_div ? mag_a : mag_b;
                            mcand   <= is_div ? mag_b : mag_a;
                            res_neg <= (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (funct3_q[2]) begin
                        acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
                        acc_hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    write_reg  <= rd_q;
                    write_data <= result;
                    RegWrite   <= (rd_q != 5'd0);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus a scoreboard queue
// of expected writes, with hand sequences for start-during-CALC and mid-op reset.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        start;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        RegWrite;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    localparam int NVEC = 23;
    vec_t vecs [0:NVEC-1];
    exp_t sb_q [$];

    muldiv_unit #(.XLEN(32)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .start      (start),
        .funct3     (funct3),
        .rd         (rd),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .write_reg  (write_reg),
        .write_data (write_data),
        .RegWrite   (RegWrite)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic got, input int n,
                                input int lat, input int busy_gaps);
        exp_t e;
        checks++;
        if (!got) begin
            fails++;
            $display("[TB] FAIL %s timeout: no done after %0d cycles, expected at %0d", name, n, lat);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            return;
        end
        e = sb_q.pop_front();
        check_val({name, " latency"}, 32'(n), 32'(lat));
        check_val({name, " busy gaps"}, 32'(busy_gaps), 32'd0);
        check_val({name, " write_data"}, write_data, e.data);
        check_val({name, " write_reg"}, {27'd0, write_reg}, {27'd0, e.rd});
        check_val({name, " RegWrite"}, {31'd0, RegWrite}, {31'd0, (e.rd != 5'd0)});
        check_val({name, " busy at done"}, {31'd0, busy}, 32'd1);
        @(posedge CLK); #1;
        check_val({name, " done pulse width"}, {31'd0, done}, 32'd0);
        check_val({name, " busy after done"}, {31'd0, busy}, 32'd0);
        check_val({name, " RegWrite after done"}, {31'd0, RegWrite}, 32'd0);
        check_val({name, " data after done"}, write_data, 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v, input int poke);
        exp_t e;
        int   n;
        int   busy_gaps;
        logic got;
        @(negedge CLK);
        start  = 1'b1;
        funct3 = v.f3;
        op_a   = v.a;
        op_b   = v.b;
        rd     = v.rd;
        @(posedge CLK); #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        rd     = 5'($urandom);
        e.data = v.exp;
        e.rd   = v.rd;
        sb_q.push_back(e);
        n = 0;
        busy_gaps = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            if (!busy) busy_gaps++;
            start = (poke != 0 && n == poke);
            if (start) begin
                funct3 = 3'b100;
                op_a   = 32'h0000_0064;
                op_b   = 32'h0000_0003;
                rd     = 5'd1;
            end
            @(posedge CLK); #1;
            start = 1'b0;
            n++;
            if (done) got = 1'b1;
        end
        check_output(v.name, got, n, v.lat, busy_gaps);
    endtask

    initial begin
        vec_t v;
        int   done_seen;

        vecs[0]  = '{"mul_neg",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{"mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33};
        vecs[2]  = '{"mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{"mulhsu",       3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div_neg",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{"rem_neg",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{"divu",         3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        33};
        vecs[7]  = '{"remu",         3'd7, 32'd100,       32'd7,         5'd13, 32'd2,         33};
        vecs[8]  = '{"divu_zero",    3'd5, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{"rem_zero",     3'd6, 32'd5,         32'd0,         5'd15, 32'd5,         1};
        vecs[10] = '{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1};
        vecs[11] = '{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1};
        vecs[12] = '{"mul_plain",    3'd0, 32'h1234_5678, 32'h0000_0010, 5'd18, 32'h2345_6780, 33};
        vecs[13] = '{"mulh_mixed",   3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 5'd19, 32'hFFFF_FFFF, 33};
        vecs[14] = '{"div_pos_neg",  3'd4, 32'd100,       32'hFFFF_FFF9, 5'd20, 32'hFFFF_FFF2, 33};
        vecs[15] = '{"rem_pos_neg",  3'd6, 32'd100,       32'hFFFF_FFF9, 5'd21, 32'd2,         33};
        vecs[16] = '{"mulhu_small",  3'd3, 32'h8000_0000, 32'h0000_0004, 5'd22, 32'd2,         33};
        vecs[17] = '{"divu_big",     3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,         33};
        vecs[18] = '{"div_min_one",  3'd4, 32'h8000_0000, 32'h0000_0001, 5'd24, 32'h8000_0000, 33};
        vecs[19] = '{"remu_zero",    3'd7, 32'd5,         32'd0,         5'd25, 32'd5,         1};
        vecs[20] = '{"mul_rd0",      3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        33};
        vecs[21] = '{"div_neg_neg",  3'd4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd26, 32'd14,        33};
        vecs[22] = '{"rem_neg_neg",  3'd6, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd27, 32'hFFFF_FFFE, 33};

        RSTn   = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        rd     = 5'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        #2;
        check_val("reset busy", {31'd0, busy}, 32'd0);
        check_val("reset done", {31'd0, done}, 32'd0);
        check_val("reset write_reg", {27'd0, write_reg}, 32'd0);
        check_val("reset write_data", write_data, 32'd0);
        check_val("reset RegWrite", {31'd0, RegWrite}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i], 0);
        end

        v = '{"mul_start_ignored", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 33};
        apply_stimulus(v, 10);

        // Abort a multiply mid-CALC with reset; nothing may be written afterwards
        @(negedge CLK);
        start  = 1'b1;
        funct3 = 3'd0;
        op_a   = 32'd11;
        op_b   = 32'd13;
        rd     = 5'd3;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        check_val("abort busy", {31'd0, busy}, 32'd0);
        check_val("abort done", {31'd0, done}, 32'd0);
        check_val("abort write_reg", {27'd0, write_reg}, 32'd0);
        check_val("abort write_data", write_data, 32'd0);
        check_val("abort RegWrite", {31'd0, RegWrite}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (done || RegWrite || busy) done_seen++;
        end
        check_val("abort no activity", 32'(done_seen), 32'd0);

        v = '{"divu_after_reset", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 33};
        apply_stimulus(v, 0);

        check_val("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
